// File: rtl/sram_req_adapter.sv
// Valid/ready request stream to single-port SRAM, one in-order response per accepted request.
// Response Latency+1 cycles after accept; req_ready_o drops once RespDepth responses are owed.

module sram_req_adapter_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             i_push,
   input  logic [Width-1:0] i_dat,
   input  logic             i_pop,
   output logic [Width-1:0] o_dat,
   output logic             o_empty
);
   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);
   localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

   logic [Width-1:0] r_mem [Depth];
   logic [PtrW-1:0]  r_wptr;
   logic [PtrW-1:0]  r_rptr;
   logic [CntW-1:0]  r_cnt;
   logic             w_pop;

   assign o_empty = (r_cnt == '0);
   assign w_pop   = i_pop && !o_empty;
   // Head is forced to zero while empty so idle outputs read as 0.
   assign o_dat   = o_empty ? '0 : r_mem[r_rptr];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (i_push) begin
            r_wptr <= (r_wptr == LastPtr) ? '0 : r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= (r_rptr == LastPtr) ? '0 : r_rptr + 1'b1;
         end
         case ({i_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (i_push) begin
         r_mem[r_wptr] <= i_dat;
      end
   end
endmodule

module sram_req_adapter #(
   parameter int unsigned NumWords  = 1024,
   parameter int unsigned DataWidth = 64,
   parameter int unsigned ByteWidth = 8,
   parameter int unsigned Latency   = 1,
   parameter int unsigned RespDepth = 2,
   parameter int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
   parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic                 req_we_i,
   input  logic [31:0]          req_addr_i,
   input  logic [DataWidth-1:0] req_wdata_i,
   input  logic [BeWidth-1:0]   req_be_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [DataWidth-1:0] rsp_rdata_o,
   output logic                 rsp_err_o,
   output logic                 sram_req_o,
   output logic                 sram_we_o,
   output logic [AddrWidth-1:0] sram_addr_o,
   output logic [DataWidth-1:0] sram_wdata_o,
   output logic [BeWidth-1:0]   sram_be_o,
   input  logic [DataWidth-1:0] sram_rdata_i
);
   localparam int unsigned CntW = $clog2(RespDepth + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(RespDepth);

   logic [CntW-1:0]    r_cnt;
   logic [Latency-1:0] r_trk_vld;
   logic [Latency-1:0] r_trk_rd;
   logic [Latency-1:0] r_trk_err;

   logic                 w_accept;
   logic                 w_in_range;
   logic                 w_rsp_hs;
   logic                 w_empty;
   logic                 w_push;
   logic [DataWidth-1:0] w_push_rdata;
   logic [DataWidth:0]   w_push_dat;
   logic [DataWidth:0]   w_head;

   // Credits cover both in-flight reads and buffered responses, so the
   // never-stalling SRAM data always finds a free FIFO slot.
   assign req_ready_o = (r_cnt < CntMax);
   assign w_accept    = req_valid_i && req_ready_o;
   assign w_in_range  = (req_addr_i < NumWords);
   assign w_rsp_hs    = rsp_valid_o && rsp_ready_i;

   assign sram_req_o   = w_accept && w_in_range;
   assign sram_we_o    = req_we_i;
   assign sram_addr_o  = req_addr_i[AddrWidth-1:0];
   assign sram_wdata_o = req_wdata_i;
   assign sram_be_o    = req_be_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= '0;
      end else begin
         case ({w_accept, w_rsp_hs})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_trk_vld <= '0;
         r_trk_rd  <= '0;
         r_trk_err <= '0;
      end else begin
         r_trk_vld[0] <= w_accept;
         r_trk_rd[0]  <= !req_we_i;
         r_trk_err[0] <= !w_in_range;
         for (int unsigned i = 1; i < Latency; i++) begin
            r_trk_vld[i] <= r_trk_vld[i-1];
            r_trk_rd[i]  <= r_trk_rd[i-1];
            r_trk_err[i] <= r_trk_err[i-1];
         end
      end
   end

   // The tail lines up with the cycle the macro presents read data.
   assign w_push       = r_trk_vld[Latency-1];
   assign w_push_rdata = (r_trk_rd[Latency-1] && !r_trk_err[Latency-1]) ? sram_rdata_i : '0;
   assign w_push_dat   = {r_trk_err[Latency-1], w_push_rdata};

   sram_req_adapter_fifo #(
      .Width (DataWidth + 1),
      .Depth (RespDepth)
   ) u_rsp_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .i_push  (w_push),
      .i_dat   (w_push_dat),
      .i_pop   (w_rsp_hs),
      .o_dat   (w_head),
      .o_empty (w_empty)
   );

   assign rsp_valid_o = !w_empty;
   assign rsp_err_o   = w_head[DataWidth];
   assign rsp_rdata_o = w_head[DataWidth-1:0];
endmodule

// File: tb/tb_sram_req_adapter.sv
// Bench for sram_req_adapter: two instances (Latency 1 / depth 2 and Latency 2 / depth 4)
// sharing one request stream, each backed by a small SRAM model and checked against a queue.

module tb_sram_req_adapter;
   localparam int NW = 16;

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic        rst_ni = 1'b0;
   logic        sel = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic [7:0]  req_be = '0;
   logic        rsp_ready = 1'b0;
   logic        a_vld, b_vld;
   assign a_vld = req_valid && !sel;
   assign b_vld = req_valid && sel;

   logic        a_req_ready, a_rsp_valid, a_rsp_err, a_sram_req, a_sram_we;
   logic [63:0] a_rsp_rdata, a_sram_wdata, a_sram_rdata;
   logic [3:0]  a_sram_addr;
   logic [7:0]  a_sram_be;
   logic        b_req_ready, b_rsp_valid, b_rsp_err, b_sram_req, b_sram_we;
   logic [63:0] b_rsp_rdata, b_sram_wdata, b_sram_rdata, b_rd0;
   logic [3:0]  b_sram_addr;
   logic [7:0]  b_sram_be;

   sram_req_adapter #(.NumWords(NW), .DataWidth(64), .ByteWidth(8), .Latency(1), .RespDepth(2)) u_dut_a (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(a_vld), .req_ready_o(a_req_ready), .req_we_i(req_we), .req_addr_i(req_addr),
      .req_wdata_i(req_wdata), .req_be_i(req_be),
      .rsp_valid_o(a_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(a_rsp_rdata), .rsp_err_o(a_rsp_err),
      .sram_req_o(a_sram_req), .sram_we_o(a_sram_we), .sram_addr_o(a_sram_addr),
      .sram_wdata_o(a_sram_wdata), .sram_be_o(a_sram_be), .sram_rdata_i(a_sram_rdata));

   // Depth Latency+2 covers the round trip through the registered ready.
   sram_req_adapter #(.NumWords(NW), .DataWidth(64), .ByteWidth(8), .Latency(2), .RespDepth(4)) u_dut_b (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(b_vld), .req_ready_o(b_req_ready), .req_we_i(req_we), .req_addr_i(req_addr),
      .req_wdata_i(req_wdata), .req_be_i(req_be),
      .rsp_valid_o(b_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(b_rsp_rdata), .rsp_err_o(b_rsp_err),
      .sram_req_o(b_sram_req), .sram_we_o(b_sram_we), .sram_addr_o(b_sram_addr),
      .sram_wdata_o(b_sram_wdata), .sram_be_o(b_sram_be), .sram_rdata_i(b_sram_rdata));

   // SRAM macro models; write cycles return garbage that the adapter must zero.
   logic [63:0] sram_a [NW];
   logic [63:0] sram_b [NW];
   always @(posedge clk_i) begin
      if (a_sram_req) begin
         if (a_sram_we) begin
            for (int i = 0; i < 8; i++) if (a_sram_be[i]) sram_a[a_sram_addr][8*i +: 8] <= a_sram_wdata[8*i +: 8];
            a_sram_rdata <= 64'hBAD0_BAD0_BAD0_BAD0;
         end else a_sram_rdata <= sram_a[a_sram_addr];
      end else a_sram_rdata <= 64'h5A5A_5A5A_5A5A_5A5A;
   end
   always @(posedge clk_i) begin
      if (b_sram_req) begin
         if (b_sram_we) begin
            for (int i = 0; i < 8; i++) if (b_sram_be[i]) sram_b[b_sram_addr][8*i +: 8] <= b_sram_wdata[8*i +: 8];
            b_rd0 <= 64'hBAD1_BAD1_BAD1_BAD1;
         end else b_rd0 <= sram_b[b_sram_addr];
      end else b_rd0 <= 64'h5A5A_5A5A_5A5A_5A5A;
      b_sram_rdata <= b_rd0;
   end

   logic [63:0] ref_a [NW];
   logic [63:0] ref_b [NW];
   logic [64:0] exp_q [$];
   logic [64:0] obs_q [$];
   int          obs_cyc [$];
   int          obs_rd = 0;
   int          cyc = 0;
   int          a_sreq_n = 0;
   int          checks = 0;
   int          errors = 0;

   always @(posedge clk_i) cyc <= cyc + 1;

   always @(negedge clk_i) begin
      if (rst_ni && rsp_ready && a_rsp_valid) begin
         obs_q.push_back({a_rsp_err, a_rsp_rdata});
         obs_cyc.push_back(cyc);
      end
      if (rst_ni && rsp_ready && b_rsp_valid) begin
         obs_q.push_back({b_rsp_err, b_rsp_rdata});
         obs_cyc.push_back(cyc);
      end
      if (a_sram_req) a_sreq_n <= a_sreq_n + 1;
   end

   // Drive one request on the selected instance, hold until accepted, push its expected response.
   task automatic send(input logic we, input logic [31:0] addr, input logic [63:0] d,
                       input logic [7:0] be, output int acc, output int stalls);
      logic [64:0] e;
      req_we = we; req_addr = addr; req_wdata = d; req_be = be; req_valid = 1'b1;
      acc = -1; stalls = 0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk_i);
         if (sel ? b_req_ready : a_req_ready) begin
            acc = cyc;
            break;
         end
         stalls++;
      end
      if (acc < 0) begin
         checks++; errors++;
         $display("FAIL send_timeout addr %0d: ready stayed 0, required 1", addr);
      end else begin
         if (addr >= NW) e = {1'b1, 64'h0};
         else if (we) begin
            for (int b = 0; b < 8; b++) begin
               if (be[b] && sel)  ref_b[addr[3:0]][8*b +: 8] = d[8*b +: 8];
               if (be[b] && !sel) ref_a[addr[3:0]][8*b +: 8] = d[8*b +: 8];
            end
            e = {1'b0, 64'h0};
         end else e = {1'b0, sel ? ref_b[addr[3:0]] : ref_a[addr[3:0]]};
         exp_q.push_back(e);
      end
      @(posedge clk_i); #1;
      req_valid = 1'b0;
   endtask

   task automatic get_rsp(output logic [64:0] o, output int c);
      for (int n = 0; n < 100 && obs_q.size() <= obs_rd; n++) @(negedge clk_i);
      if (obs_q.size() <= obs_rd) begin
         checks++; errors++;
         $display("FAIL rsp_timeout: no response, required one");
         o = 'x; c = -1;
      end else begin
         o = obs_q[obs_rd]; c = obs_cyc[obs_rd]; obs_rd++;
      end
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      repeat (3) @(posedge clk_i);
      #1 rst_ni = 1'b1;
      @(negedge clk_i);
      checks++;
      if ({a_req_ready, a_rsp_valid, a_rsp_err, a_sram_req, a_rsp_rdata} !== {4'b1000, 64'h0}) begin
         errors++; $display("FAIL reset_a got %b/%h required 1000/0",
                            {a_req_ready, a_rsp_valid, a_rsp_err, a_sram_req}, a_rsp_rdata);
      end
      checks++;
      if ({b_req_ready, b_rsp_valid, b_rsp_err, b_sram_req, b_rsp_rdata} !== {4'b1000, 64'h0}) begin
         errors++; $display("FAIL reset_b got %b/%h required 1000/0",
                            {b_req_ready, b_rsp_valid, b_rsp_err, b_sram_req}, b_rsp_rdata);
      end
      @(posedge clk_i); #1;
   endtask

   task automatic test_fill(input logic s);
      int acc, st, c;
      logic [64:0] o, e;
      sel = s; rsp_ready = 1'b1;
      for (int i = 0; i < NW; i++) send(1'b1, i, {(s ? 32'hB000_0000 : 32'hA000_0000) | i, $urandom}, 8'hFF, acc, st);
      for (int i = 0; i < NW; i++) begin
         get_rsp(o, c); e = exp_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL fill%0d[%0d] got %h required %h", s, i, o, e); end
      end
      @(posedge clk_i); #1;
   endtask

   task automatic test_write_read();
      int tw, tr, st, c;
      logic [64:0] o, e;
      sel = 1'b0; rsp_ready = 1'b1;
      send(1'b1, 5, 64'hDEAD_BEEF, 8'hFF, tw, st);
      send(1'b0, 5, 64'h0, 8'hFF, tr, st);
      get_rsp(o, c); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL wr_rsp got %h required %h", o, e); end
      get_rsp(o, c); e = exp_q.pop_front(); checks++;
      if (o !== {1'b0, 64'h0000_0000_DEAD_BEEF}) begin errors++; $display("FAIL rd_rsp got %h required DEADBEEF", o); end
      checks++;
      if (c !== tr + 2) begin errors++; $display("FAIL rd_latency got cycle %0d required %0d", c, tr + 2); end
      @(posedge clk_i); #1;
   endtask

   task automatic test_partial();
      int acc, st, c;
      logic [64:0] o, e;
      sel = 1'b0; rsp_ready = 1'b1;
      send(1'b1, 7, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, acc, st);
      send(1'b1, 7, 64'h0, 8'h0F, acc, st);
      send(1'b0, 7, 64'h0, 8'hFF, acc, st);
      for (int i = 0; i < 3; i++) begin
         get_rsp(o, c); e = exp_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL partial[%0d] got %h required %h", i, o, e); end
      end
      checks++;
      if (o[63:0] !== 64'hFFFF_FFFF_0000_0000) begin
         errors++; $display("FAIL partial_data got %h required FFFFFFFF00000000", o[63:0]);
      end
      @(posedge clk_i); #1;
   endtask

   task automatic test_err();
      int acc, st, c, n0;
      logic [64:0] o, e;
      logic [2:0] errs;
      sel = 1'b0; rsp_ready = 1'b1; n0 = a_sreq_n;
      send(1'b0, 3, 64'h0, 8'hFF, acc, st);
      send(1'b0, NW + 4, 64'h0, 8'hFF, acc, st);
      send(1'b0, 3, 64'h0, 8'hFF, acc, st);
      for (int i = 0; i < 3; i++) begin
         get_rsp(o, c); e = exp_q.pop_front(); errs[2-i] = o[64]; checks++;
         if (o !== e) begin errors++; $display("FAIL err_seq[%0d] got %h required %h", i, o, e); end
      end
      checks++;
      if (errs !== 3'b010) begin errors++; $display("FAIL err_pattern got %b required 010", errs); end
      checks++;
      if (a_sreq_n - n0 !== 2) begin errors++; $display("FAIL err_sram_req got %0d required 2", a_sreq_n - n0); end
      @(posedge clk_i); #1;
   endtask

   task automatic test_backpressure();
      int acc, c;
      logic took;
      logic [64:0] o, e;
      sel = 1'b0; rsp_ready = 1'b0; acc = 0;
      req_we = 1'b0; req_be = 8'hFF; req_addr = 8; req_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk_i);
         took = a_req_ready;
         if (took) begin exp_q.push_back({1'b0, ref_a[req_addr[3:0]]}); acc++; end
         @(posedge clk_i); #1;
         if (took) req_addr = req_addr + 1;
      end
      req_valid = 1'b0;
      checks++;
      if (acc !== 2) begin errors++; $display("FAIL bp_accepts got %0d required 2", acc); end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk_i); checks++;
         if ({a_req_ready, a_rsp_valid, a_rsp_err, a_rsp_rdata} !== {2'b01, exp_q[0]}) begin
            errors++; $display("FAIL bp_hold[%0d] got %b%b/%h required 01/%h", k, a_req_ready, a_rsp_valid,
                               {a_rsp_err, a_rsp_rdata}, exp_q[0]);
         end
      end
      @(posedge clk_i); #1 rsp_ready = 1'b1;
      @(posedge clk_i); #1 rsp_ready = 1'b0;
      @(negedge clk_i); checks++;
      if (a_req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %b required 1", a_req_ready); end
      @(posedge clk_i); #1 rsp_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         get_rsp(o, c); e = exp_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL bp_rsp[%0d] got %h required %h", i, o, e); end
      end
      @(posedge clk_i); #1;
   endtask

   task automatic test_back_to_back();
      int acc, st, t0, tot, c;
      logic [64:0] o, e;
      sel = 1'b1; rsp_ready = 1'b1; tot = 0; t0 = 0;
      for (int i = 0; i < 8; i++) begin
         send(1'b0, i, 64'h0, 8'hFF, acc, st);
         if (i == 0) t0 = acc;
         tot += st;
      end
      checks++;
      if (tot !== 0) begin errors++; $display("FAIL b2b_stalls got %0d required 0", tot); end
      for (int i = 0; i < 8; i++) begin
         get_rsp(o, c); e = exp_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL b2b_data[%0d] got %h required %h", i, o, e); end
         checks++;
         if (c !== t0 + 3 + i) begin errors++; $display("FAIL b2b_cycle[%0d] got %0d required %0d", i, c, t0 + 3 + i); end
      end
      @(posedge clk_i); #1;
   endtask

   task automatic test_reset_mid();
      int acc, st, c;
      logic [64:0] o, e;
      sel = 1'b1; rsp_ready = 1'b0;
      send(1'b0, 1, 64'h0, 8'hFF, acc, st);
      send(1'b0, 2, 64'h0, 8'hFF, acc, st);
      send(1'b0, 3, 64'h0, 8'hFF, acc, st);
      @(negedge clk_i); checks++;
      if (b_rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b required 1", b_rsp_valid); end
      #1 rst_ni = 1'b0;
      #1 checks++;
      if ({b_rsp_valid, b_req_ready} !== 2'b01) begin
         errors++; $display("FAIL mid_reset got valid %b ready %b required 0 1", b_rsp_valid, b_req_ready);
      end
      exp_q.delete();
      @(posedge clk_i); @(posedge clk_i); #1 rst_ni = 1'b1;
      rsp_ready = 1'b1;
      send(1'b0, 2, 64'h0, 8'hFF, acc, st);
      get_rsp(o, c); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL mid_after got %h required %h", o, e); end
      repeat (6) @(negedge clk_i);
      checks++;
      if (obs_q.size() !== obs_rd) begin errors++; $display("FAIL mid_stale got %0d extra required 0", obs_q.size() - obs_rd); end
   endtask

   initial begin
      test_reset();
      test_fill(1'b0);
      test_fill(1'b1);
      test_write_read();
      test_partial();
      test_err();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
